inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Buffers fetched instructions between the instruction-fetch memory port and the way0 decoder, and issues them in program order over a valid/ready handshake.
- Tags each instruction with a 2-bit packet ID (pID) that travels down the pipeline.
- Sits at the IFU output and drives the decoder's valid_i/inst_i/instAddr_i/way0_pID_i; the decoder's ready_o comes back as this block's ready_i.
- Supports a flush for redirects.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived; do not override).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- fetch_valid_i  input  1  fetch port presents an instruction
- fetch_inst_i  input  32  fetched instruction word
- fetch_addr_i  input  32  address of the fetched instruction
- fetch_ready_o  output  1  queue can accept this cycle
- flush_i  input  1  discard all queued entries (redirect)
- valid_o  output  1  head entry valid, to decoder
- inst_o  output  32  head instruction
- instAddr_o  output  32  head instruction address
- way0_pID_o  output  2  head entry pID
- ready_i  input  1  decoder accepts head this cycle
- count_o  output  PTR_W+1  current occupancy (debug/perf)

Interface: single clock domain on clk. rst is asynchronous and active-high: assertion immediately clears all state; release is taken on a clk edge.

Behaviour:
- Storage: DEPTH entries of {inst[31:0], addr[31:0], pID[1:0]}. Write pointer, read pointer and count are registers.
- Reset values:
  - Pointers, count and the pID counter are 0.
  - valid_o=0 and fetch_ready_o=1.
  - inst_o, instAddr_o and way0_pID_o read 0 (entry storage is cleared on reset).
- Enqueue:
  - Occurs when fetch_valid_i && fetch_ready_o && !flush_i.
  - Stores the entry at the write pointer with pID = the pID counter.
  - Increments the write pointer modulo DEPTH and the pID counter modulo 4 (3 wraps to 0).
- Dequeue:
  - Occurs when valid_o && ready_i && !flush_i.
  - Increments the read pointer modulo DEPTH.
- Ready/valid rules:
  - fetch_ready_o = (count != DEPTH). It is registered-state only, with no combinational dependence on ready_i. When full, a same-cycle dequeue does not allow an enqueue.
  - valid_o = (count != 0). inst_o, instAddr_o and way0_pID_o are read combinationally from the head entry.
  - Outputs are held stable while valid_o && !ready_i.
- Count update:
  - Simultaneous enqueue and dequeue (count not 0 and not DEPTH): count unchanged.
  - Enqueue only: count+1. Dequeue only: count-1.
- Latency:
  - An instruction enqueued at edge N is visible on valid_o after edge N (earliest dequeue in cycle N+1).
  - There is no bypass from fetch to the decoder when empty.
- Ordering: strict FIFO. pID values on consecutive dequeued instructions increment by 1 mod 4.
- Flush (flush_i=1 at an edge):
  - Pointers, count and pID counter go to 0.
  - Any enqueue or dequeue in the same cycle is ignored; flush wins.
  - valid_o=0 in the following cycle. fetch_ready_o=1 in the following cycle.
  - Entry contents need not be cleared.
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no gap. Full is distinguished from empty by count only.
- Reset mid-operation: asynchronous assertion clears all state immediately. Queued entries are lost and valid_o drops without waiting for clk.
- Illegal input: fetch_valid_i while full is not an error; the producer holds the data until fetch_ready_o.

Test Plan:
- Basic flow: reset; push 0x00000013@0x80000000 with ready_i=1 -> valid_o=1 next cycle with inst_o=0x00000013, instAddr_o=0x80000000, way0_pID_o=0; count_o returns to 0 after the handshake.
- Fill/backpressure: ready_i=0; push 5 instructions at 0x80000000+4k -> fetch_ready_o=0 after the 4th enqueue; the 5th is held; head stays at 0x80000000/pID 0 and stable. Raise ready_i -> dequeue order is addr 0x80000000..0x80000010 with pID 0,1,2,3,0.
- Simultaneous enqueue/dequeue at count=2 for 10 cycles -> count_o stays 2; pointers wrap at least twice; no loss or duplication (scoreboard compares addr sequence).
- Flush with pending traffic: count=3, flush_i=1 together with fetch_valid_i=1 and ready_i=1 -> next cycle valid_o=0, count_o=0, no handshake counted; the next push gets pID 0.
- Async reset mid-stream: assert rst between clk edges with count=2 -> valid_o=0 and fetch_ready_o=1 before the next edge; after release, the first push carries pID 0.
- pID wrap: stream 9 instructions with ready_i=1 -> way0_pID_o sequence 0,1,2,3,0,1,2,3,0.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: buffers fetched words between the fetch port and the
// way0 decoder, tags each one with a rolling 2-bit pID and issues in program order.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid_i,
  input  logic [31:0]      fetch_inst_i,
  input  logic [31:0]      fetch_addr_i,
  output logic             fetch_ready_o,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [31:0]      inst_o,
  output logic [31:0]      instAddr_o,
  output logic [1:0]       way0_pID_o,
  input  logic             ready_i,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      addr_mem [DEPTH];
  logic [1:0]       pid_mem  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [1:0]       pid_cnt;
  logic             enq;
  logic             deq;

  // Ready depends on stored occupancy only, so a full queue cannot take a
  // word even when the head drains in the same cycle.
  assign fetch_ready_o = (count != FULL_CNT);
  assign valid_o       = (count != '0);
  assign enq           = fetch_valid_i && fetch_ready_o && !flush_i;
  assign deq           = valid_o && ready_i && !flush_i;

  assign inst_o     = inst_mem[rd_ptr];
  assign instAddr_o = addr_mem[rd_ptr];
  assign way0_pID_o = pid_mem[rd_ptr];
  assign count_o    = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pid_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        addr_mem[i] <= '0;
        pid_mem[i]  <= '0;
      end
    end else if (flush_i) begin
      // Stale entries stay in storage; they are unreachable once count is 0.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pid_cnt <= '0;
    end else begin
      if (enq) begin
        inst_mem[wr_ptr] <= fetch_inst_i;
        addr_mem[wr_ptr] <= fetch_addr_i;
        pid_mem[wr_ptr]  <= pid_cnt;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        pid_cnt          <= pid_cnt + 2'd1;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a queue-based reference model is
// compared against the DUT every cycle, plus directed checks per scenario.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid_i;
  logic [31:0] fetch_inst_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_ready_o;
  logic        flush_i;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] instAddr_o;
  logic [1:0]  way0_pID_o;
  logic        ready_i;
  logic [2:0]  count_o;

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid_i(fetch_valid_i), .fetch_inst_i(fetch_inst_i), .fetch_addr_i(fetch_addr_i),
    .fetch_ready_o(fetch_ready_o), .flush_i(flush_i),
    .valid_o(valid_o), .inst_o(inst_o), .instAddr_o(instAddr_o), .way0_pID_o(way0_pID_o),
    .ready_i(ready_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [1:0]  pid;
  } entry_t;

  entry_t q[$];
  int     m_pid;
  int     m_enqs;
  int     n_pass;
  int     n_total;

  logic        obs_valid, obs_ready, obs_hs;
  logic [2:0]  obs_count;
  entry_t      obs_head;
  logic [70:0] obs_vec, exp_vec;

  // Sample DUT at the falling edge, snapshot model expectation, then advance
  // the model on the rising edge using the inputs that the DUT saw.
  task automatic cycle();
    entry_t hd;
    bit     m_enq, m_deq;
    @(negedge clk);
    obs_valid = valid_o;
    obs_ready = fetch_ready_o;
    obs_count = count_o;
    obs_head  = '{inst_o, instAddr_o, way0_pID_o};
    obs_hs    = valid_o && ready_i && !flush_i;
    hd        = (q.size() != 0) ? q[0] : entry_t'('0);
    obs_vec   = {obs_valid, obs_ready, obs_count, (q.size() != 0) ? obs_head : entry_t'('0)};
    exp_vec   = {q.size() != 0, q.size() != DEPTH, 3'(q.size()), hd};
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_pid = 0;
    end else if (flush_i) begin
      q.delete();
      m_pid = 0;
    end else begin
      m_deq = (q.size() != 0) && ready_i;
      m_enq = fetch_valid_i && (q.size() != DEPTH);
      if (m_deq) void'(q.pop_front());
      if (m_enq) begin
        q.push_back('{fetch_inst_i, fetch_addr_i, 2'(m_pid)});
        m_pid  = (m_pid + 1) % 4;
        m_enqs = m_enqs + 1;
      end
    end
    #1;
  endtask

  task automatic do_flush();
    fetch_valid_i = 1'b0;
    ready_i       = 1'b0;
    flush_i       = 1'b1;
    cycle();
    flush_i       = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_o); else n_pass++;
    n_total++; if (fetch_ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", fetch_ready_o); else n_pass++;
    n_total++; if (count_o !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count_o); else n_pass++;
    n_total++; if ({inst_o, instAddr_o, way0_pID_o} !== 66'd0)
      $display("FAIL reset_head got=%h/%h/%0d exp=0/0/0", inst_o, instAddr_o, way0_pID_o); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    fetch_valid_i = 1'b1;
    fetch_inst_i  = 32'h0000_0013;
    fetch_addr_i  = 32'h8000_0000;
    ready_i       = 1'b1;
    cycle();
    n_total++; if (obs_vec !== exp_vec) $display("FAIL basic_model got=%h exp=%h", obs_vec, exp_vec); else n_pass++;
    fetch_valid_i = 1'b0;
    cycle();
    n_total++; if (obs_vec !== exp_vec) $display("FAIL basic_model got=%h exp=%h", obs_vec, exp_vec); else n_pass++;
    n_total++; if (!(obs_valid === 1'b1 && obs_head === entry_t'({32'h13, 32'h8000_0000, 2'd0})))
      $display("FAIL basic_head got=%b %h exp=1 %h", obs_valid, obs_head, {32'h13, 32'h8000_0000, 2'd0}); else n_pass++;
    cycle();
    n_total++; if (obs_count !== 3'd0) $display("FAIL basic_drain got=%0d exp=0", obs_count); else n_pass++;
  endtask

  task automatic test_fill_backpressure();
    int start, got;
    logic [31:0] base;
    base = 32'h8000_0000;
    do_flush();
    start = m_enqs;
    got   = 0;
    fetch_valid_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      fetch_addr_i = base + 32'(4 * (m_enqs - start));
      fetch_inst_i = fetch_addr_i ^ 32'hA5A5_0000;
      cycle();
      n_total++; if (obs_vec !== exp_vec) $display("FAIL fill_model got=%h exp=%h", obs_vec, exp_vec); else n_pass++;
      if (c >= 4) begin
        n_total++; if (obs_ready !== 1'b0) $display("FAIL fill_ready got=%b exp=0", obs_ready); else n_pass++;
        n_total++; if (obs_head.addr !== base || obs_head.pid !== 2'd0)
          $display("FAIL fill_head got=%h/%0d exp=%h/0", obs_head.addr, obs_head.pid, base); else n_pass++;
      end
    end
    ready_i = 1'b1;
    for (int c = 0; c < 16 && got < 5; c++) begin
      fetch_valid_i = (m_enqs - start) < 5;
      fetch_addr_i  = base + 32'(4 * (m_enqs - start));
      fetch_inst_i  = fetch_addr_i ^ 32'hA5A5_0000;
      cycle();
      n_total++; if (obs_vec !== exp_vec) $display("FAIL fill_model got=%h exp=%h", obs_vec, exp_vec); else n_pass++;
      if (obs_hs) begin
        n_total++; if (obs_head.addr !== base + 32'(4 * got) || obs_head.pid !== 2'(got % 4))
          $display("FAIL fill_order got=%h/%0d exp=%h/%0d", obs_head.addr, obs_head.pid, base + 32'(4 * got), got % 4); else n_pass++;
        got++;
      end
    end
    n_total++; if (got !== 5) $display("FAIL fill_drain_timeout got=%0d exp=5", got); else n_pass++;
    fetch_valid_i = 1'b0;
  endtask

  task automatic test_simultaneous();
    int start, got;
    logic [31:0] base;
    base = 32'h4000_0100;
    do_flush();
    start = m_enqs;
    got   = 0;
    fetch_valid_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      fetch_addr_i = base + 32'(4 * (m_enqs - start));
      fetch_inst_i = $urandom;
      cycle();
    end
    ready_i = 1'b1;
    for (int c = 0; c < 14; c++) begin
      fetch_valid_i = c < 10;
      fetch_addr_i  = base + 32'(4 * (m_enqs - start));
      fetch_inst_i  = $urandom;
      cycle();
      n_total++; if (obs_vec !== exp_vec) $display("FAIL simul_model got=%h exp=%h", obs_vec, exp_vec); else n_pass++;
      if (c < 10) begin
        n_total++; if (obs_count !== 3'd2) $display("FAIL simul_count got=%0d exp=2", obs_count); else n_pass++;
      end
      if (obs_hs) begin
        n_total++; if (obs_head.addr !== base + 32'(4 * got))
          $display("FAIL simul_order got=%h exp=%h", obs_head.addr, base + 32'(4 * got)); else n_pass++;
        got++;
      end
    end
    n_total++; if (got !== 12) $display("FAIL simul_total got=%0d exp=12", got); else n_pass++;
  endtask

  task automatic test_flush();
    do_flush();
    fetch_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      fetch_addr_i = 32'h2000_0000 + 32'(4 * c);
      fetch_inst_i = $urandom;
      cycle();
    end
    flush_i = 1'b1;
    ready_i = 1'b1;
    cycle();
    n_total++; if (obs_count !== 3'd3) $display("FAIL flush_pre_count got=%0d exp=3", obs_count); else n_pass++;
    flush_i      = 1'b0;
    ready_i      = 1'b0;
    fetch_addr_i = 32'h9000_0000;
    fetch_inst_i = 32'h1234_5678;
    cycle();
    n_total++; if (obs_valid !== 1'b0 || obs_count !== 3'd0 || obs_ready !== 1'b1)
      $display("FAIL flush_empty got=%b/%0d/%b exp=0/0/1", obs_valid, obs_count, obs_ready); else n_pass++;
    fetch_valid_i = 1'b0;
    cycle();
    n_total++; if (obs_vec !== exp_vec) $display("FAIL flush_model got=%h exp=%h", obs_vec, exp_vec); else n_pass++;
    n_total++; if (obs_valid !== 1'b1 || obs_head.pid !== 2'd0 || obs_head.addr !== 32'h9000_0000)
      $display("FAIL flush_next_pid got=%b/%0d/%h exp=1/0/90000000", obs_valid, obs_head.pid, obs_head.addr); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_flush();
    fetch_valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      fetch_addr_i = 32'h3000_0000 + 32'(4 * c);
      fetch_inst_i = $urandom;
      cycle();
    end
    fetch_valid_i = 1'b0;
    ready_i       = 1'b1;
    cycle();
    ready_i = 1'b0;
    n_total++; if (count_o !== 3'd2) $display("FAIL areset_pre_count got=%0d exp=2", count_o); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (valid_o !== 1'b0 || fetch_ready_o !== 1'b1 || count_o !== 3'd0)
      $display("FAIL areset_immediate got=%b/%b/%0d exp=0/1/0", valid_o, fetch_ready_o, count_o); else n_pass++;
    q.delete();
    m_pid = 0;
    cycle();
    n_total++; if (obs_vec !== exp_vec) $display("FAIL areset_model got=%h exp=%h", obs_vec, exp_vec); else n_pass++;
    rst           = 1'b0;
    fetch_valid_i = 1'b1;
    fetch_addr_i  = 32'h3000_0100;
    fetch_inst_i  = $urandom;
    cycle();
    fetch_valid_i = 1'b0;
    cycle();
    n_total++; if (obs_valid !== 1'b1 || obs_head.pid !== 2'd0)
      $display("FAIL areset_pid got=%b/%0d exp=1/0", obs_valid, obs_head.pid); else n_pass++;
  endtask

  task automatic test_pid_wrap();
    int got;
    logic [1:0] exp_seq [9];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_flush();
    got     = 0;
    ready_i = 1'b1;
    for (int c = 0; c < 20 && got < 9; c++) begin
      fetch_valid_i = c < 9;
      fetch_addr_i  = 32'h5000_0000 + 32'(4 * c);
      fetch_inst_i  = $urandom;
      cycle();
      n_total++; if (obs_vec !== exp_vec) $display("FAIL pid_model got=%h exp=%h", obs_vec, exp_vec); else n_pass++;
      if (obs_hs) begin
        n_total++; if (obs_head.pid !== exp_seq[got])
          $display("FAIL pid_seq[%0d] got=%0d exp=%0d", got, obs_head.pid, exp_seq[got]); else n_pass++;
        got++;
      end
    end
    n_total++; if (got !== 9) $display("FAIL pid_timeout got=%0d exp=9", got); else n_pass++;
    fetch_valid_i = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      fetch_valid_i = $urandom_range(0, 3) != 0;
      ready_i       = $urandom_range(0, 2) != 0;
      flush_i       = $urandom_range(0, 24) == 0;
      fetch_inst_i  = $urandom;
      fetch_addr_i  = $urandom;
      cycle();
      n_total++; if (obs_vec !== exp_vec) $display("FAIL random_model cyc=%0d got=%h exp=%h", c, obs_vec, exp_vec); else n_pass++;
    end
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    m_pid         = 0;
    m_enqs        = 0;
    rst           = 1'b1;
    fetch_valid_i = 1'b0;
    fetch_inst_i  = '0;
    fetch_addr_i  = '0;
    flush_i       = 1'b0;
    ready_i       = 1'b0;
    test_reset();
    test_basic();
    test_fill_backpressure();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_pid_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
